// File: rtl/clk_en_pkg.sv
// Shared definitions for the clock-enable generator.
//   CFG_CHAN_W      width of the configuration channel index
//   DIV_EXT_W       internal arithmetic width; one bit wider than the largest
//                   supported ratio (32 bits) so that (d+1) cannot overflow
//   ST_SETTLE/ST_RUN  controller state encodings
//   eff_div()       clamps a ratio of 0 to 1
//   hi_len()        high-phase length of the square strobe, (d+1)>>1
package clk_en_pkg;

    localparam int CFG_CHAN_W = 4;
    localparam int DIV_EXT_W  = 33;

    localparam logic [0:0] ST_SETTLE = 1'b0;
    localparam logic [0:0] ST_RUN    = 1'b1;

    function automatic logic [DIV_EXT_W-1:0] eff_div(input logic [DIV_EXT_W-1:0] d);
        return (d == '0) ? DIV_EXT_W'(1) : d;
    endfunction

    // Odd ratios give the extra cycle to the high phase.
    function automatic logic [DIV_EXT_W-1:0] hi_len(input logic [DIV_EXT_W-1:0] d);
        return (d + DIV_EXT_W'(1)) >> 1;
    endfunction

endpackage

// File: rtl/clk_en_chan.sv
// One divider channel of the clock-enable generator.
// Ports:
//   i_refclk  reference clock, rising edge
//   i_rst     synchronous active-high reset
//   i_clr     hold counter at 0 and outputs low (next cycle is a settle cycle)
//   i_run     advance the counter; when low (and not cleared) the counter is
//             loaded with 0, which is how the first RUN cycle starts aligned
//   i_div     divide ratio (0 is treated as 1)
//   o_en      one-cycle enable pulse, high where the counter hits ratio-1
//   o_sq      square strobe, high for the first (ratio+1)>>1 counts
module clk_en_chan
    import clk_en_pkg::*;
#(
    parameter int DIV_W = 16
) (
    input  logic             i_refclk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_en,
    output logic             o_sq
);

    logic [DIV_W-1:0]     r_cnt;
    logic                 r_en;
    logic                 r_sq;
    logic [DIV_W-1:0]     w_cnt_d;
    logic [DIV_EXT_W-1:0] w_eff;
    logic [DIV_EXT_W-1:0] w_last;
    logic [DIV_EXT_W-1:0] w_hi;
    logic [DIV_EXT_W-1:0] w_cnt_ext;
    logic [DIV_EXT_W-1:0] w_cnt_d_ext;

    always_comb begin
        w_eff     = eff_div(DIV_EXT_W'(i_div));
        w_last    = w_eff - DIV_EXT_W'(1);
        w_hi      = hi_len(w_eff);
        w_cnt_ext = DIV_EXT_W'(r_cnt);
        w_cnt_d   = '0;
        if (i_run && (w_cnt_ext != w_last)) begin
            w_cnt_d = r_cnt + DIV_W'(1);
        end
        w_cnt_d_ext = DIV_EXT_W'(w_cnt_d);
    end

    // Outputs are registered from the next count so they line up with r_cnt.
    always_ff @(posedge i_refclk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
            r_en  <= 1'b0;
            r_sq  <= 1'b0;
        end else begin
            r_cnt <= w_cnt_d;
            r_en  <= (w_cnt_d_ext == w_last);
            r_sq  <= (w_cnt_d_ext < w_hi);
        end
    end

    assign o_en = r_en;
    assign o_sq = r_sq;

endmodule

// File: rtl/clk_en_gen.sv
// N-channel clock-enable generator with run-time programmable divide ratios.
// After reset or any accepted in-range reconfiguration, all channels are held
// for LOCK_CYCLES settle cycles and then restart together, phase-aligned.
// Ports:
//   i_refclk      sole clock, rising edge
//   i_rst         synchronous active-high reset
//   i_cfg_valid   config request
//   o_cfg_ready   config accept, high only while running
//   i_cfg_chan    target channel; indices >= N_CHAN are accepted and dropped
//   i_cfg_div     new divide ratio for i_cfg_chan
//   o_outclk_en   per-channel one-cycle enable pulse
//   o_outclk_sq   per-channel square-wave strobe
//   o_locked      high when all channels are running and aligned
module clk_en_gen
    import clk_en_pkg::*;
#(
    parameter int                      N_CHAN      = 3,
    parameter int                      DIV_W       = 16,
    parameter logic [N_CHAN*DIV_W-1:0] DIV_INIT    = {16'd4, 16'd2, 16'd1},
    parameter int                      LOCK_CYCLES = 16
) (
    input  logic                  i_refclk,
    input  logic                  i_rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [CFG_CHAN_W-1:0] i_cfg_chan,
    input  logic [DIV_W-1:0]      i_cfg_div,
    output logic [N_CHAN-1:0]     o_outclk_en,
    output logic [N_CHAN-1:0]     o_outclk_sq,
    output logic                  o_locked
);

    localparam int SC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_d;
    logic [SC_W-1:0]  r_settle_cnt;
    logic [SC_W-1:0]  w_settle_cnt_d;
    logic             r_locked;
    logic             r_cfg_ready;
    logic [DIV_W-1:0] r_div [N_CHAN];
    logic             w_cfg_hit;
    logic             w_clr;
    logic             w_run;

    assign w_cfg_hit = i_cfg_valid && r_cfg_ready && (int'(i_cfg_chan) < N_CHAN);

    always_comb begin
        w_state_d      = r_state;
        w_settle_cnt_d = r_settle_cnt;
        case (r_state)
            ST_SETTLE: begin
                if (r_settle_cnt == SC_W'(LOCK_CYCLES - 1)) begin
                    w_state_d      = ST_RUN;
                    w_settle_cnt_d = '0;
                end else begin
                    w_settle_cnt_d = r_settle_cnt + SC_W'(1);
                end
            end
            ST_RUN: begin
                if (w_cfg_hit) begin
                    w_state_d      = ST_SETTLE;
                    w_settle_cnt_d = '0;
                end
            end
            default: begin
                w_state_d      = ST_SETTLE;
                w_settle_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= '0;
            r_locked     <= 1'b0;
            r_cfg_ready  <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_settle_cnt <= w_settle_cnt_d;
            r_locked     <= (w_state_d == ST_RUN);
            r_cfg_ready  <= (w_state_d == ST_RUN);
        end
    end

    always_ff @(posedge i_refclk) begin
        if (i_rst) begin
            for (int i = 0; i < N_CHAN; i++) begin
                r_div[i] <= DIV_INIT[i*DIV_W +: DIV_W];
            end
        end else if (w_cfg_hit) begin
            for (int i = 0; i < N_CHAN; i++) begin
                if (int'(i_cfg_chan) == i) begin
                    r_div[i] <= i_cfg_div;
                end
            end
        end
    end

    // Clear while the next cycle is a settle cycle; on the SETTLE->RUN edge
    // neither clr nor run is set, so every channel loads 0 at the same time.
    assign w_clr = (w_state_d == ST_SETTLE);
    assign w_run = (r_state == ST_RUN);

    for (genvar g = 0; g < N_CHAN; g++) begin : g_chan
        clk_en_chan #(
            .DIV_W (DIV_W)
        ) u_chan (
            .i_refclk (i_refclk),
            .i_rst    (i_rst),
            .i_clr    (w_clr),
            .i_run    (w_run),
            .i_div    (r_div[g]),
            .o_en     (o_outclk_en[g]),
            .o_sq     (o_outclk_sq[g])
        );
    end

    assign o_locked    = r_locked;
    assign o_cfg_ready = r_cfg_ready;

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

    logic        refclk = 1'b0;
    logic        rst    = 1'b1;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [3:0]  cfg_chan = 4'd0;
    logic [15:0] cfg_div  = 16'd0;
    logic [2:0]  outclk_en;
    logic [2:0]  outclk_sq;
    logic        locked;

    always #5 refclk = ~refclk;

    clk_en_gen #(
        .N_CHAN      (3),
        .DIV_W       (16),
        .DIV_INIT    ({16'd4, 16'd2, 16'd1}),
        .LOCK_CYCLES (16)
    ) dut (
        .i_refclk    (refclk),
        .i_rst       (rst),
        .i_cfg_valid (cfg_valid),
        .o_cfg_ready (cfg_ready),
        .i_cfg_chan  (cfg_chan),
        .i_cfg_div   (cfg_div),
        .o_outclk_en (outclk_en),
        .o_outclk_sq (outclk_sq),
        .o_locked    (locked)
    );

    // One record per clock: inputs driven before the edge, outputs expected after it.
    typedef struct {
        logic        valid;
        logic [3:0]  chan;
        logic [15:0] div;
        logic        exp_locked;
        logic        exp_ready;
        logic [2:0]  exp_en;
        logic [2:0]  exp_sq;
    } vec_t;

    vec_t vecs[$];
    int   seg_start[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void push_run(input logic [2:0] en, input logic [2:0] sq);
        vecs.push_back('{1'b0, 4'd0, 16'd0, 1'b1, 1'b1, en, sq});
    endfunction

    function automatic void push_full(input logic v, input logic [3:0] c, input logic [15:0] d,
                                      input logic [2:0] en, input logic [2:0] sq);
        vecs.push_back('{v, c, d, 1'b1, 1'b1, en, sq});
    endfunction

    task automatic step(input logic r, input logic v, input logic [3:0] c, input logic [15:0] d);
        rst       = r;
        cfg_valid = v;
        cfg_chan  = c;
        cfg_div   = d;
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string name, input logic l, input logic r,
                         input logic [2:0] e, input logic [2:0] s);
        n_vec++;
        if ({locked, cfg_ready, outclk_en, outclk_sq} !== {l, r, e, s}) begin
            n_err++;
            $display("FAIL %s: locked/ready/en/sq got %b/%b/%b/%b want %b/%b/%b/%b",
                     name, locked, cfg_ready, outclk_en, outclk_sq, l, r, e, s);
        end
    endtask

    // Settle cycles: everything low regardless of any pending request.
    task automatic settle_low(input string name, input int n, input logic v,
                              input logic [3:0] c, input logic [15:0] d);
        for (int i = 0; i < n; i++) begin
            step(1'b0, v, c, d);
            check($sformatf("%s[%0d]", name, i), 1'b0, 1'b0, 3'b000, 3'b000);
        end
    endtask

    task automatic run_seg(input int s, input string name);
        for (int i = seg_start[s]; i < seg_start[s+1]; i++) begin
            step(1'b0, vecs[i].valid, vecs[i].chan, vecs[i].div);
            check($sformatf("%s[%0d]", name, i - seg_start[s]), vecs[i].exp_locked,
                  vecs[i].exp_ready, vecs[i].exp_en, vecs[i].exp_sq);
        end
    endtask

    initial begin
        // Seg 0: defaults (1,2,4) from the first locked cycle.
        seg_start.push_back(vecs.size());
        for (int r = 0; r < 2; r++) begin
            push_run(3'b001, 3'b111);
            push_run(3'b011, 3'b101);
            push_run(3'b001, 3'b011);
            push_run(3'b111, 3'b001);
        end
        // Seg 1: ratios (1,5,4).
        seg_start.push_back(vecs.size());
        push_run(3'b001, 3'b111);
        push_run(3'b001, 3'b111);
        push_run(3'b001, 3'b011);
        push_run(3'b101, 3'b001);
        push_run(3'b011, 3'b101);
        push_run(3'b001, 3'b111);
        push_run(3'b001, 3'b011);
        push_run(3'b101, 3'b011);
        push_run(3'b001, 3'b101);
        push_run(3'b011, 3'b101);
        // Seg 2: ratios (1,5,0->1).
        seg_start.push_back(vecs.size());
        push_run(3'b101, 3'b111);
        push_run(3'b101, 3'b111);
        push_run(3'b101, 3'b111);
        push_run(3'b101, 3'b101);
        push_run(3'b111, 3'b101);
        push_run(3'b101, 3'b111);
        // Seg 3: out-of-range channel write, phases continue undisturbed.
        seg_start.push_back(vecs.size());
        push_full(1'b1, 4'd7, 16'd9, 3'b101, 3'b111);
        push_run(3'b101, 3'b111);
        push_run(3'b101, 3'b101);
        push_run(3'b111, 3'b101);
        // Seg 4: defaults restored after reset.
        seg_start.push_back(vecs.size());
        push_run(3'b001, 3'b111);
        push_run(3'b011, 3'b101);
        push_run(3'b001, 3'b011);
        push_run(3'b111, 3'b001);
        // Seg 5: ratios (3,2,4).
        seg_start.push_back(vecs.size());
        push_run(3'b000, 3'b111);
        push_run(3'b010, 3'b101);
        push_run(3'b001, 3'b010);
        push_run(3'b110, 3'b001);
        push_run(3'b000, 3'b111);
        push_run(3'b011, 3'b100);
        push_run(3'b000, 3'b011);
        seg_start.push_back(vecs.size());

        // Reset held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 4'd0, 16'd0);
            check($sformatf("reset[%0d]", i), 1'b0, 1'b0, 3'b000, 3'b000);
        end
        settle_low("settle0", 15, 1'b0, 4'd0, 16'd0);
        run_seg(0, "defaults");

        // Channel 1 -> 5: accept drops ready at T+1, everything re-aligns.
        step(1'b0, 1'b1, 4'd1, 16'd5);
        check("cfg_ch1_accept", 1'b0, 1'b0, 3'b000, 3'b000);
        settle_low("settle1", 15, 1'b0, 4'd0, 16'd0);
        run_seg(1, "ch1_div5");

        // Channel 2 -> 0, behaves as ratio 1.
        step(1'b0, 1'b1, 4'd2, 16'd0);
        check("cfg_ch2_accept", 1'b0, 1'b0, 3'b000, 3'b000);
        settle_low("settle2", 15, 1'b0, 4'd0, 16'd0);
        run_seg(2, "ch2_div0");

        run_seg(3, "chan7_drop");

        // Reset 5 cycles into a settle restores DIV_INIT.
        step(1'b0, 1'b1, 4'd0, 16'd3);
        check("cfg_ch0_accept", 1'b0, 1'b0, 3'b000, 3'b000);
        settle_low("settle3", 5, 1'b0, 4'd0, 16'd0);
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b0, 4'd0, 16'd0);
            check($sformatf("mid_settle_rst[%0d]", i), 1'b0, 1'b0, 3'b000, 3'b000);
        end
        settle_low("settle4", 15, 1'b0, 4'd0, 16'd0);
        run_seg(4, "reset_defaults");

        // Reset and a request together from RUN: reset wins. The request is
        // then held through the settle and only accepted once ready is seen.
        step(1'b1, 1'b1, 4'd0, 16'd3);
        check("rst_vs_cfg", 1'b0, 1'b0, 3'b000, 3'b000);
        settle_low("settle_held", 15, 1'b1, 4'd0, 16'd3);
        step(1'b0, 1'b1, 4'd0, 16'd3);
        check("first_run_not_taken", 1'b1, 1'b1, 3'b001, 3'b111);
        step(1'b0, 1'b1, 4'd0, 16'd3);
        check("held_cfg_accept", 1'b0, 1'b0, 3'b000, 3'b000);
        settle_low("settle5", 15, 1'b0, 4'd0, 16'd0);
        run_seg(5, "ch0_div3");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
